// File: rtl/riscv_defs.sv
// riscv_defs: definitions shared by the RISCVunicycle support blocks.
// Contents:
//   XLEN              - machine word width
//   DEFAULT_BASE_ADDR - default byte address of the loaded instruction image
//   loader_state_t    - imem_loader FSM state encodings
//   csum_add          - checksum accumulate (sum modulo 2^XLEN)
package riscv_defs;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } loader_state_t;

   // The carry out of bit XLEN-1 is dropped, which gives the modulo-2^XLEN sum.
   function automatic logic [XLEN-1:0] csum_add(input logic [XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] word);
      csum_add = acc + word;
   endfunction

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: packs a little-endian byte stream into XLEN-bit words.
// Ports:
//   clock     in   rising-edge clock
//   rst       in   asynchronous active-high reset (drops any partial word)
//   clr       in   synchronous clear of the word and the byte index
//   byte_en   in   accept byte_in on this edge
//   byte_in   in   8-bit stream byte
//   word      out  assembly register; holds the complete word after byte 3
//   last_byte out  the next accepted byte completes the word (byte index == 3)
module loader_word_asm
   import riscv_defs::*;
(
   input  logic            clock,
   input  logic            rst,
   input  logic            clr,
   input  logic            byte_en,
   input  logic [7:0]      byte_in,
   output logic [XLEN-1:0] word,
   output logic            last_byte
);

   logic [XLEN-1:0] word_r;
   logic [1:0]      byte_idx_r;

   // Shift register plus byte index. Each new byte enters at the top and
   // moves down, so after four bytes byte k sits in bits [8k+7:8k].
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         word_r     <= {XLEN{1'b0}};
         byte_idx_r <= 2'd0;
      end else if (clr) begin
         word_r     <= {XLEN{1'b0}};
         byte_idx_r <= 2'd0;
      end else if (byte_en) begin
         word_r     <= {byte_in, word_r[XLEN-1:8]};
         byte_idx_r <= byte_idx_r + 2'd1;   // 3 wraps to 0
      end
   end

   assign word      = word_r;
   assign last_byte = (byte_idx_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads NUM_WORDS instruction words from a byte stream into
// instruction memory and holds the core in reset until the image is in place.
// Ports:
//   clock      in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   byte stream valid
//   in_data    in   byte stream data, little-endian within a word
//   in_ready   out  a byte is accepted this cycle when in_valid is also high
//   reload     in   single-cycle restart request, honoured only once DONE
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  word-aligned byte address of the current write
//   imem_wdata out  word being written
//   cpu_rst    out  core reset, released only once DONE
//   done       out  load complete
//   checksum   out  sum modulo 2^32 of all words written in this load
module imem_loader
   import riscv_defs::*;
#(
   parameter int              NUM_WORDS = 64,
   parameter logic [XLEN-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
)
(
   input  logic            clock,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [7:0]      in_data,
   output logic            in_ready,
   input  logic            reload,
   output logic            imem_we,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] imem_wdata,
   output logic            cpu_rst,
   output logic            done,
   output logic [XLEN-1:0] checksum
);

   // One spare bit so the count can reach NUM_WORDS after the final write
   // without wrapping.
   localparam int               CNT_W    = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   loader_state_t   state_r;
   loader_state_t   state_s;
   logic [CNT_W-1:0] word_cnt_r;
   logic [XLEN-1:0] addr_r;
   logic [XLEN-1:0] checksum_r;
   logic            in_ready_r;
   logic            imem_we_r;
   logic            done_r;
   logic            cpu_rst_r;
   logic            accept_s;
   logic            clr_s;
   logic            leave_write_s;
   logic [XLEN-1:0] asm_word_s;
   logic            last_byte_s;

   assign accept_s      = in_valid & in_ready_r;
   assign leave_write_s = (state_r == WRITE);

   loader_word_asm u_word_asm (
      .clock     (clock),
      .rst       (rst),
      .clr       (clr_s),
      .byte_en   (accept_s),
      .byte_in   (in_data),
      .word      (asm_word_s),
      .last_byte (last_byte_s)
   );

   // Next-state logic; clr_s restarts the load when reload arrives in DONE.
   always_comb begin
      state_s = state_r;
      clr_s   = 1'b0;
      case (state_r)
         LOAD: begin
            if (accept_s && last_byte_s) begin
               state_s = WRITE;
            end else begin
               state_s = LOAD;
            end
         end
         WRITE: begin
            if (word_cnt_r == LAST_IDX) begin
               state_s = DONE;
            end else begin
               state_s = LOAD;
            end
         end
         DONE: begin
            if (reload) begin
               state_s = LOAD;
               clr_s   = 1'b1;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = LOAD;
         end
      endcase
   end

   // State register; the status outputs are decoded from the next state so
   // they are registered yet always agree with the current state.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_r    <= LOAD;
         in_ready_r <= 1'b1;
         imem_we_r  <= 1'b0;
         done_r     <= 1'b0;
         cpu_rst_r  <= 1'b1;
      end else begin
         state_r    <= state_s;
         in_ready_r <= (state_s == LOAD);
         imem_we_r  <= (state_s == WRITE);
         done_r     <= (state_s == DONE);
         cpu_rst_r  <= (state_s != DONE);
      end
   end

   // Word counter, write address and checksum advance as WRITE is left.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         word_cnt_r <= {CNT_W{1'b0}};
         addr_r     <= BASE_ADDR;
         checksum_r <= {XLEN{1'b0}};
      end else if (clr_s) begin
         word_cnt_r <= {CNT_W{1'b0}};
         addr_r     <= BASE_ADDR;
         checksum_r <= {XLEN{1'b0}};
      end else if (leave_write_s) begin
         word_cnt_r <= word_cnt_r + CNT_W'(1);
         addr_r     <= addr_r + 32'd4;
         checksum_r <= csum_add(checksum_r, asm_word_s);
      end
   end

   assign in_ready   = in_ready_r;
   assign imem_we    = imem_we_r;
   assign imem_addr  = addr_r;
   assign imem_wdata = asm_word_s;
   assign cpu_rst    = cpu_rst_r;
   assign done       = done_r;
   assign checksum   = checksum_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// DUT a: NUM_WORDS=2, BASE_ADDR=0. DUT b: NUM_WORDS=1, BASE_ADDR=0x100.
module tb_imem_loader;

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  d;
      logic        rl;
      logic        rdy;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic        dn;
      logic        cpu;
      logic [31:0] cs;
   } vec_t;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        reload = 1'b0;
   logic        in_ready, imem_we, cpu_rst, done;
   logic [31:0] imem_addr, imem_wdata, checksum;

   logic        rst_b = 1'b1;
   logic        in_valid_b = 1'b0;
   logic [7:0]  in_data_b = 8'h00;
   logic        reload_b = 1'b0;
   logic        in_ready_b, imem_we_b, cpu_rst_b, done_b;
   logic [31:0] imem_addr_b, imem_wdata_b, checksum_b;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   imem_loader #(.NUM_WORDS(2), .BASE_ADDR(32'h0000_0000)) dut_a (
      .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
      .done(done), .checksum(checksum)
   );

   imem_loader #(.NUM_WORDS(1), .BASE_ADDR(32'h0000_0100)) dut_b (
      .clock(clock), .rst(rst_b), .in_valid(in_valid_b), .in_data(in_data_b),
      .in_ready(in_ready_b), .reload(reload_b), .imem_we(imem_we_b),
      .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b), .cpu_rst(cpu_rst_b),
      .done(done_b), .checksum(checksum_b)
   );

   always #5 clock = ~clock;

   // Row builders: expected outputs are written out per row.
   function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic rl, logic rdy,
                               logic we, logic [31:0] a, logic [31:0] wd,
                               logic dn, logic cpu, logic [31:0] cs);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.rl = rl; t.rdy = rdy; t.we = we;
      t.a = a; t.wd = wd; t.dn = dn; t.cpu = cpu; t.cs = cs;
      return t;
   endfunction
   function automatic vec_t R(logic v, logic [7:0] d);
      return mk(1'b1, v, d, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
   endfunction
   function automatic vec_t L(logic v, logic [7:0] d, logic rl, logic [31:0] cs);
      return mk(1'b0, v, d, rl, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, cs);
   endfunction
   function automatic vec_t W(logic v, logic [7:0] d, logic rl, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] cs);
      return mk(1'b0, v, d, rl, 1'b0, 1'b1, a, wd, 1'b0, 1'b1, cs);
   endfunction
   function automatic vec_t D(logic v, logic [7:0] d, logic rl, logic [31:0] cs);
      return mk(1'b0, v, d, rl, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, cs);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply_a(vec_t t, int i);
      @(negedge clock);
      rst = t.rst; in_valid = t.v; in_data = t.d; reload = t.rl;
      @(posedge clock);
      #1;
      chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, t.rdy});
      chk($sformatf("row%0d imem_we", i), {31'd0, imem_we}, {31'd0, t.we});
      chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, t.dn});
      chk($sformatf("row%0d cpu_rst", i), {31'd0, cpu_rst}, {31'd0, t.cpu});
      chk($sformatf("row%0d checksum", i), checksum, t.cs);
      if (t.we) begin
         chk($sformatf("row%0d imem_addr", i), imem_addr, t.a);
         chk($sformatf("row%0d imem_wdata", i), imem_wdata, t.wd);
      end
   endtask

   initial begin
      // Reset state
      tbl.push_back(R(1'b0, 8'h00));
      // Full-rate image: 13 00 50 00 / 93 00 10 00; 93 is also held through WRITE
      tbl.push_back(L(1'b1, 8'h13, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'h00, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'h50, 1'b0, 32'h0));
      tbl.push_back(W(1'b1, 8'h00, 1'b0, 32'h0, 32'h0050_0013, 32'h0));
      tbl.push_back(L(1'b1, 8'h93, 1'b0, 32'h0050_0013));
      tbl.push_back(L(1'b1, 8'h93, 1'b0, 32'h0050_0013));
      tbl.push_back(L(1'b1, 8'h00, 1'b0, 32'h0050_0013));
      tbl.push_back(L(1'b1, 8'h10, 1'b0, 32'h0050_0013));
      tbl.push_back(W(1'b1, 8'h00, 1'b0, 32'h4, 32'h0010_0093, 32'h0050_0013));
      tbl.push_back(D(1'b0, 8'h00, 1'b0, 32'h0060_00A6));
      tbl.push_back(D(1'b1, 8'h55, 1'b0, 32'h0060_00A6));
      // Reload in DONE, then a toggled-valid second image with junk bytes
      // while invalid; reload pulsed in LOAD and in WRITE is ignored.
      tbl.push_back(L(1'b0, 8'h00, 1'b1, 32'h0));
      tbl.push_back(L(1'b1, 8'h11, 1'b0, 32'h0));
      tbl.push_back(L(1'b0, 8'hEE, 1'b1, 32'h0));
      tbl.push_back(L(1'b1, 8'h22, 1'b0, 32'h0));
      tbl.push_back(L(1'b0, 8'hEE, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'h33, 1'b0, 32'h0));
      tbl.push_back(L(1'b0, 8'hEE, 1'b0, 32'h0));
      tbl.push_back(W(1'b1, 8'h44, 1'b0, 32'h0, 32'h4433_2211, 32'h0));
      tbl.push_back(L(1'b0, 8'hEE, 1'b1, 32'h4433_2211));
      tbl.push_back(L(1'b1, 8'h55, 1'b0, 32'h4433_2211));
      tbl.push_back(L(1'b0, 8'hEE, 1'b0, 32'h4433_2211));
      tbl.push_back(L(1'b1, 8'h66, 1'b0, 32'h4433_2211));
      tbl.push_back(L(1'b0, 8'hEE, 1'b0, 32'h4433_2211));
      tbl.push_back(L(1'b1, 8'h77, 1'b0, 32'h4433_2211));
      tbl.push_back(L(1'b0, 8'hEE, 1'b0, 32'h4433_2211));
      tbl.push_back(W(1'b1, 8'h88, 1'b0, 32'h4, 32'h8877_6655, 32'h4433_2211));
      tbl.push_back(D(1'b0, 8'hEE, 1'b0, 32'hCCAA_8866));
      // Reload, one word, two bytes of word 1, then rst
      tbl.push_back(L(1'b0, 8'h00, 1'b1, 32'h0));
      tbl.push_back(L(1'b1, 8'hA1, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'hB2, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'hC3, 1'b0, 32'h0));
      tbl.push_back(W(1'b1, 8'hD4, 1'b0, 32'h0, 32'hD4C3_B2A1, 32'h0));
      tbl.push_back(L(1'b1, 8'hE5, 1'b0, 32'hD4C3_B2A1));
      tbl.push_back(L(1'b1, 8'hE5, 1'b0, 32'hD4C3_B2A1));
      tbl.push_back(L(1'b1, 8'hF6, 1'b0, 32'hD4C3_B2A1));
      tbl.push_back(R(1'b1, 8'h07));
      // Reload from byte 0 after rst: word 0 again at BASE_ADDR, fresh checksum
      tbl.push_back(L(1'b1, 8'h01, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'h02, 1'b0, 32'h0));
      tbl.push_back(L(1'b1, 8'h03, 1'b0, 32'h0));
      tbl.push_back(W(1'b1, 8'h04, 1'b0, 32'h0, 32'h0403_0201, 32'h0));
      tbl.push_back(L(1'b0, 8'h00, 1'b0, 32'h0403_0201));
      tbl.push_back(L(1'b1, 8'h10, 1'b0, 32'h0403_0201));
      tbl.push_back(L(1'b1, 8'h20, 1'b0, 32'h0403_0201));
      tbl.push_back(L(1'b1, 8'h30, 1'b0, 32'h0403_0201));
      tbl.push_back(W(1'b1, 8'h40, 1'b0, 32'h4, 32'h4030_2010, 32'h0403_0201));
      tbl.push_back(D(1'b0, 8'h00, 1'b0, 32'h4433_2211));

      repeat (2) @(posedge clock);
      foreach (tbl[i]) apply_a(tbl[i], i);

      // Reset asserted asynchronously while the write strobe is high
      apply_a(L(1'b0, 8'h00, 1'b1, 32'h0), 100);
      apply_a(L(1'b1, 8'h5A, 1'b0, 32'h0), 101);
      apply_a(L(1'b1, 8'h6B, 1'b0, 32'h0), 102);
      apply_a(L(1'b1, 8'h7C, 1'b0, 32'h0), 103);
      apply_a(W(1'b1, 8'h8D, 1'b0, 32'h0, 32'h8D7C_6B5A, 32'h0), 104);
      #2 rst = 1'b1;
      #1;
      chk("async imem_we", {31'd0, imem_we}, 32'd0);
      chk("async in_ready", {31'd0, in_ready}, 32'd1);
      chk("async imem_wdata", imem_wdata, 32'h0);
      chk("async checksum", checksum, 32'h0);
      chk("async cpu_rst", {31'd0, cpu_rst}, 32'd1);
      apply_a(R(1'b1, 8'h99), 105);
      apply_a(L(1'b1, 8'hC0, 1'b0, 32'h0), 106);
      apply_a(L(1'b1, 8'hC1, 1'b0, 32'h0), 107);
      apply_a(L(1'b1, 8'hC2, 1'b0, 32'h0), 108);
      apply_a(W(1'b1, 8'hC3, 1'b0, 32'h0, 32'hC3C2_C1C0, 32'h0), 109);
      apply_a(L(1'b0, 8'h00, 1'b0, 32'hC3C2_C1C0), 110);

      // NUM_WORDS=1, BASE_ADDR=0x100, bytes FF FF FF FF
      @(negedge clock);
      chk("b reset in_ready", {31'd0, in_ready_b}, 32'd1);
      chk("b reset cpu_rst", {31'd0, cpu_rst_b}, 32'd1);
      chk("b reset checksum", checksum_b, 32'h0);
      rst_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         in_valid_b = 1'b1;
         in_data_b  = 8'hFF;
         @(posedge clock);
         #1;
         chk($sformatf("b byte%0d imem_we", k), {31'd0, imem_we_b}, {31'd0, (k == 3)});
      end
      chk("b imem_addr", imem_addr_b, 32'h0000_0100);
      chk("b imem_wdata", imem_wdata_b, 32'hFFFF_FFFF);
      chk("b done before", {31'd0, done_b}, 32'd0);
      @(negedge clock);
      in_valid_b = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("b done%0d", k), {31'd0, done_b}, 32'd1);
         chk($sformatf("b cpu_rst%0d", k), {31'd0, cpu_rst_b}, 32'd0);
         chk($sformatf("b we%0d", k), {31'd0, imem_we_b}, 32'd0);
         chk($sformatf("b checksum%0d", k), checksum_b, 32'hFFFF_FFFF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter NUM_WORDS, default 64; number of 32-bit instruction words loaded before CPU release.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000; byte address of the first word written.
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  byte stream valid.
REQ-006 Port in_data  input  8  byte stream data, little-endian within each word.
REQ-007 Port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port reload  input  1  single-cycle request to restart loading.
REQ-009 Port imem_we  output  1  instruction-memory write strobe.
REQ-010 Port imem_addr  output  32  instruction-memory byte address, word aligned.
REQ-011 Port imem_wdata  output  32  instruction-memory write data.
REQ-012 Port cpu_rst  output  1  active-high reset driven to the RISCVunicycle core.
REQ-013 Port done  output  1  load complete.
REQ-014 Port checksum  output  32  running sum of all written words, modulo 2^32.

Function
REQ-015 States SHALL be LOAD, WRITE, DONE; reset state LOAD.
REQ-016 Byte transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-017 in_ready SHALL equal 1 in LOAD and 0 in WRITE and DONE.
REQ-018 Byte k (k=0..3) of a word SHALL land in imem_wdata bits [8k+7:8k]; a 2-bit byte index SHALL wrap 3->0.
REQ-019 Acceptance of byte 3 SHALL move LOAD->WRITE on the same edge.
REQ-020 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*word_cnt and imem_wdata equal to the assembled word.
REQ-021 On leaving WRITE, checksum SHALL increase by imem_wdata and word_cnt SHALL increment.
REQ-022 WRITE SHALL go to DONE when the written word was index NUM_WORDS-1; otherwise it SHALL return to LOAD.
REQ-023 Latency: last byte accepted on edge N -> imem_we high during cycle N..N+1 -> next byte acceptable at edge N+2.
REQ-024 imem_we SHALL be 0 in LOAD and DONE.
REQ-025 cpu_rst SHALL be 1 in LOAD and WRITE and 0 in DONE; done SHALL be 1 only in DONE.
REQ-026 reload SHALL be honoured only in DONE: next state LOAD, word_cnt, byte index and checksum cleared, cpu_rst reasserted the following cycle.
REQ-027 reload in LOAD or WRITE SHALL be ignored; a partial word SHALL not be discarded by it.
REQ-028 NUM_WORDS=1 SHALL reach DONE after the first WRITE.
REQ-029 word_cnt SHALL be wide enough for NUM_WORDS-1 and SHALL never wrap within one load.

Reset
REQ-030 rst=1 SHALL asynchronously force: state LOAD, byte index 0, word_cnt 0, imem_wdata 0, checksum 0, imem_we 0, done 0, cpu_rst 1, in_ready 1 (following from LOAD).
REQ-031 rst asserted mid-word or mid-WRITE SHALL discard the partial word, with no write strobe issued after the assertion.
REQ-032 After rst deasserts, the first accepted byte SHALL be byte 0 of word 0.

Structure
REQ-033 State encodings, XLEN=32 and the default BASE_ADDR SHALL live in the shared riscv_defs package/header.
REQ-034 Byte-to-word assembly (shift register plus byte index) SHALL be one sub-module, loader_word_asm; FSM, counters and checksum stay in imem_loader.

Verification
REQ-035 NUM_WORDS=2, bytes 13,00,50,00 then 93,00,10,00 at full rate -> writes 32'h00500013 @0x0 and 32'h00100093 @0x4, checksum 32'h006000A6, done=1, cpu_rst=0.
REQ-036 in_valid toggled 1/0 every cycle with in_data changing while in_valid=0 -> identical words as the full-rate run; no extra writes.
REQ-037 in_valid held 1 through WRITE -> in_ready=0 for that cycle, no byte lost or duplicated.
REQ-038 rst pulsed after 2 bytes of word 1 -> no write for word 1; reload from byte 0 writes word 0 @BASE_ADDR again; checksum restarts at 0.
REQ-039 reload pulsed in DONE, then a second image loaded -> cpu_rst reasserts, checksum equals second image sum only; reload during LOAD has no effect.
REQ-040 NUM_WORDS=1, BASE_ADDR=32'h100, bytes FF,FF,FF,FF -> single write 32'hFFFFFFFF @0x100, checksum 32'hFFFFFFFF, done next cycle.
